// File: rtl/muu_muarbiter.sv
// muu_muarbiter: packet-atomic round-robin merge of N user streams into one tagged stream
module muu_muarbiter #(
    parameter int DATA_SIZE = 16,
    parameter int USER_BITS = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [(2**USER_BITS)-1:0]              s_axis_tvalid,
    output logic [(2**USER_BITS)-1:0]              s_axis_tready,
    input  logic [(2**USER_BITS)*DATA_SIZE-1:0]    s_axis_tdata,
    input  logic [(2**USER_BITS)-1:0]              s_axis_tlast,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic [DATA_SIZE-1:0]                   m_axis_tdata,
    output logic                                   m_axis_tlast,
    output logic [USER_BITS-1:0]                   m_axis_tusersel
);
    localparam int N = 2**USER_BITS;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic [USER_BITS-1:0] ptr;
    logic [USER_BITS-1:0] g;
    logic [USER_BITS-1:0] nxt;
    logic                 found;
    logic                 accept;

    // round-robin search from ptr; scanning backwards leaves the first hit in nxt
    always_comb begin
        logic [USER_BITS-1:0] idx;
        idx   = '0;
        nxt   = ptr;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + USER_BITS'(k);
            if (s_axis_tvalid[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

    // only the granted queue may be accepted, and only when the output slot frees up
    assign s_axis_tready = (state == LOCKED && (!m_axis_tvalid || m_axis_tready)) ? (N'(1) << g) : '0;
    assign accept        = s_axis_tvalid[g] & s_axis_tready[g];

    // arbitration: grant in IDLE, hold the grant until the packet's last beat is taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            g     <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                g     <= nxt;
                state <= LOCKED;
            end
        end else if (accept && s_axis_tlast[g]) begin
            ptr   <= g + USER_BITS'(1);
            state <= IDLE;
        end
    end

    // output register: load on accept, hold under backpressure, clear once drained
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axis_tvalid   <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tlast    <= 1'b0;
            m_axis_tusersel <= '0;
        end else if (accept) begin
            m_axis_tvalid   <= 1'b1;
            m_axis_tdata    <= s_axis_tdata[DATA_SIZE*g +: DATA_SIZE];
            m_axis_tlast    <= s_axis_tlast[g];
            m_axis_tusersel <= g;
        end else if (m_axis_tready) begin
            m_axis_tvalid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_muu_muarbiter.sv
// tb_muu_muarbiter: randomized scoreboard bench for the packet-atomic round-robin arbiter
module tb_muu_muarbiter;
    localparam int DW = 16;
    localparam int UB = 2;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    s_axis_tvalid = '0;
    logic [N-1:0]    s_axis_tready;
    logic [N*DW-1:0] s_axis_tdata = '0;
    logic [N-1:0]    s_axis_tlast = '0;
    logic            m_axis_tvalid;
    logic            m_axis_tready = 1'b0;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tlast;
    logic [UB-1:0]   m_axis_tusersel;

    muu_muarbiter #(.DATA_SIZE(DW), .USER_BITS(UB)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tusersel(m_axis_tusersel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [UB-1:0] u;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            locked;
    int            g;
    int            ptr;
    bit            mv;
    int            rem[N];
    bit            vld[N];
    logic [DW-1:0] dat[N];
    int            p_new, p_beat, p_rdy;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_axis_tvalid[i]           = vld[i];
            s_axis_tdata[i*DW +: DW]   = dat[i];
            s_axis_tlast[i]            = (rem[i] == 1);
        end
    endtask

    // reference model: one arbitration / transfer decision per clock, from queue state
    task automatic model_cycle();
        logic [N-1:0] er;
        bit           acc;
        er = (locked && (!mv || m_axis_tready)) ? (N'(1) << g) : '0;
        check("s_tready", 32'(s_axis_tready), 32'(er));
        check("m_tvalid", 32'(m_axis_tvalid), 32'(mv));
        acc = locked && vld[g] && er[g];
        if (acc) exp_q.push_back('{u: UB'(g), d: dat[g], l: (rem[g] == 1)});
        mv = acc ? 1'b1 : (m_axis_tready ? 1'b0 : mv);
        if (locked) begin
            if (acc) begin
                vld[g] = 1'b0;
                rem[g]--;
                if (rem[g] == 0) begin
                    locked = 1'b0;
                    ptr    = (g + 1) % N;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (vld[(ptr + k) % N]) begin
                    g      = (ptr + k) % N;
                    locked = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!vld[i]) begin
                if (rem[i] == 0 && $urandom_range(0, 99) < p_new) rem[i] = $urandom_range(1, 4);
                if (rem[i] > 0 && $urandom_range(0, 99) < p_beat) begin
                    vld[i] = 1'b1;
                    dat[i] = DW'($urandom);
                end
            end
        end
        drive();
        m_axis_tready = ($urandom_range(0, 99) < p_rdy);
        #1;
        model_cycle();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_m_usersel", 32'(m_axis_tusersel), 32'd0);
        locked = 1'b0; g = 0; ptr = 0; mv = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            vld[i] = 1'b0;
            dat[i] = '0;
        end
        drive();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // monitor: pops the scoreboard on every output handshake and checks stall stability
    beat_t held;
    bit    hold = 1'b0;
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(m_axis_tvalid), 32'd1);
                check("hold_data", {15'd0, m_axis_tusersel, m_axis_tdata, m_axis_tlast}, {15'd0, held});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got user %0d data %0h expected none", m_axis_tusersel, m_axis_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("usersel", 32'(m_axis_tusersel), 32'(e.u));
                    check("tdata", 32'(m_axis_tdata), 32'(e.d));
                    check("tlast", 32'(m_axis_tlast), 32'(e.l));
                end
            end
            hold = m_axis_tvalid && !m_axis_tready;
            held = '{u: m_axis_tusersel, d: m_axis_tdata, l: m_axis_tlast};
        end
    end

    initial begin
        int n;
        do_reset();
        // lone 3-beat packet on queue 2
        p_new = 0; p_beat = 100; p_rdy = 100;
        rem[2] = 3;
        run(10);
        // 2-beat packets on queues 0,1,3 from ptr 0
        do_reset();
        rem[0] = 2; rem[1] = 2; rem[3] = 2;
        run(15);
        // random traffic with gaps and backpressure
        p_new = 30; p_beat = 60; p_rdy = 60;
        run(2000);
        // heavy backpressure and sparse beats
        p_new = 50; p_beat = 30; p_rdy = 20;
        run(800);
        // reset in the middle of a packet, then queue 0 must win
        p_new = 60; p_beat = 100; p_rdy = 100;
        n = 0;
        while (!(locked && rem[g] >= 2 && mv) && n < 300) begin
            step();
            n++;
        end
        check("midpkt_found", 32'(n < 300), 32'd1);
        do_reset();
        p_new = 0;
        rem[0] = 2; rem[3] = 2;
        run(12);
        // drain everything
        p_new = 0; p_beat = 100; p_rdy = 100;
        n = 0;
        while ((exp_q.size() != 0 || mv || locked || (rem[0] | rem[1] | rem[2] | rem[3]) != 0) && n < 500) begin
            step();
            n++;
        end
        run(3);
        check("drain_done", 32'(n < 500), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muu_muarbiter.md
MUU_MUARBITER -- requirements
Module: muu_muarbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, width of each data beat.
REQ-002 SHALL have parameter USER_BITS, default 3, width of user selector; N = 2**USER_BITS input queues.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port s_axis_tvalid  input  N  per-queue beat valid.
REQ-007 SHALL have port s_axis_tready  output  N  per-queue beat accept.
REQ-008 SHALL have port s_axis_tdata  input  N*DATA_SIZE  per-queue data, queue i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-009 SHALL have port s_axis_tlast  input  N  per-queue end-of-packet.
REQ-010 SHALL have port m_axis_tvalid  output  1  merged stream valid.
REQ-011 SHALL have port m_axis_tready  input  1  merged stream accept.
REQ-012 SHALL have port m_axis_tdata  output  DATA_SIZE  merged data.
REQ-013 SHALL have port m_axis_tlast  output  1  merged end-of-packet.
REQ-014 SHALL have port m_axis_tusersel  output  USER_BITS  index of queue the current beat came from.

Function
REQ-015 SHALL merge N per-user streams into one tagged stream, packet-atomic: once a queue is granted, no other queue's beat is emitted until the granted packet's tlast beat is accepted.
REQ-016 SHALL implement FSM with states IDLE and LOCKED.
REQ-017 IDLE: SHALL search s_axis_tvalid round-robin starting at index ptr, wrapping N-1 -> 0; first valid index becomes grant g, registered; transition to LOCKED next cycle.
REQ-018 IDLE with no tvalid asserted: SHALL remain IDLE, ptr and g unchanged.
REQ-019 IDLE: all s_axis_tready SHALL be 0 (one-cycle arbitration bubble per packet).
REQ-020 LOCKED: s_axis_tready[g] SHALL equal (!m_axis_tvalid || m_axis_tready); all other tready bits 0.
REQ-021 Beat accepted from queue g (tvalid[g] && tready[g]): SHALL load output register with tdata[g], tlast[g], tusersel=g, set m_axis_tvalid=1 on next edge; latency one cycle.
REQ-022 Output register SHALL hold data/last/usersel stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 m_axis_tvalid SHALL clear when m_axis_tready=1 and no new beat is accepted that cycle; simultaneous drain and load SHALL keep valid=1 (sustains 1 beat/cycle within a packet).
REQ-024 Accepted beat with tlast[g]=1: SHALL set ptr = (g+1) mod N (wrap via USER_BITS-bit truncation) and return to IDLE next cycle.
REQ-025 Granted queue deasserting tvalid mid-packet: SHALL stay LOCKED on g indefinitely; no other queue served.
REQ-026 Single active queue: SHALL be re-granted each packet, one bubble cycle between packets.
REQ-027 Output register contents (tlast/usersel of last beat) MAY remain pending while FSM in IDLE; arbitration SHALL not wait for output drain, only REQ-020 gates acceptance.
REQ-028 Single-beat packet (tlast on first beat) SHALL be handled as REQ-024.

Reset
REQ-029 rst=0 SHALL asynchronously force: state IDLE, ptr=0, g=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tusersel=0; s_axis_tready=0 combinationally.
REQ-030 Reset mid-packet SHALL discard the in-flight beat and packet state; after release arbitration restarts from ptr=0.
REQ-031 First grant SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-032 USER_BITS=2, only queue 2 valid with 3-beat packet, m_axis_tready=1 -> beats out on m_axis with tusersel=2, last on third, ptr=3.
REQ-033 Queues 0,1,3 each hold one 2-beat packet, ptr=0 -> output order 0,0,1,1,3,3; tusersel matches; ptr ends 0 (3+1 wrap).
REQ-034 Mid-packet m_axis_tready=0 for 4 cycles -> m_axis_tdata/tlast/tusersel constant, s_axis_tready[g]=0, no beat lost or duplicated.
REQ-035 Granted queue drops tvalid 5 cycles mid-packet while queue 1 valid -> tready[1]=0 throughout, packet resumes on g, completes before queue 1 granted.
REQ-036 rst=0 asserted during beat 2 of 4 -> m_axis_tvalid=0 immediately, all tready 0; after release queue 0 (valid) granted first.
